// File: rtl/class_hvec_mem.sv
// Trainable class-hypervector store: chunk-wise write/XOR-update from the training
// path, and valid/ready streaming of one class's frames to the inference datapath.
module class_hvec_mem #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  parameter int CLASS_ID_W         = $clog2(NUM_CLASSES),
  parameter int FRAME_IDX_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          wr_mode,
  input  logic [CLASS_ID_W-1:0]         wr_class,
  input  logic [FRAME_IDX_W-1:0]        wr_frame,
  input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
  output logic                          wr_err,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CLASS_ID_W-1:0]         req_class,
  output logic                          req_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DI_PARALLEL_W_BITS-1:0] out_data,
  output logic [CLASS_ID_W-1:0]         out_class,
  output logic [FRAME_IDX_W-1:0]        out_frame,
  output logic                          out_last
);

  // Handshakes: a request transfers on a cycle where req_valid & req_ready are both
  // high at the rising edge; a beat transfers where out_valid & out_ready are both
  // high. While out_valid is high and out_ready low, all out_* fields hold stable.

  localparam int NUM_WORDS = NUM_CLASSES * NUM_FRAMES;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  state_t state;

  logic [DI_PARALLEL_W_BITS-1:0] mem [NUM_WORDS];

  logic wr_in_range;
  int   wr_idx;

  always_comb begin
    wr_in_range = (int'(wr_class) < NUM_CLASSES) && (int'(wr_frame) < NUM_FRAMES);
    wr_idx      = int'(wr_class) * NUM_FRAMES + int'(wr_frame);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_in_range;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr_en && wr_in_range && (i == wr_idx))
          mem[i] <= wr_mode ? (mem[i] ^ wr_data) : wr_data;
      end
    end
  end

  // Range-guarded read mux; reads the pre-edge value, so a same-cycle write is not seen.
  function automatic logic [DI_PARALLEL_W_BITS-1:0] word(input int c, input int f);
    logic [DI_PARALLEL_W_BITS-1:0] r;
    r = '0;
    if ((c < NUM_CLASSES) && (f < NUM_FRAMES)) begin
      for (int i = 0; i < NUM_WORDS; i++)
        if (i == c * NUM_FRAMES + f) r = mem[i];
    end
    return r;
  endfunction

  int nxt_frame;
  always_comb nxt_frame = int'(out_frame) + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      req_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
      out_frame <= '0;
      out_last  <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (int'(req_class) < NUM_CLASSES) begin
              state     <= STREAM;
              req_ready <= 1'b0;
              out_valid <= 1'b1;
              out_class <= req_class;
              out_frame <= '0;
              out_data  <= word(int'(req_class), 0);
              out_last  <= (NUM_FRAMES == 1);
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_frame <= FRAME_IDX_W'(nxt_frame);
              out_data  <= word(int'(out_class), nxt_frame);
              out_last  <= (nxt_frame == NUM_FRAMES - 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_hvec_mem.sv
// Directed bench for class_hvec_mem: a default 8-class instance and a 6-class
// instance used for the out-of-range request/write cases.
module tb_class_hvec_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance (8 classes, 3 frames)
  logic        wr_en = 0, wr_mode = 0;
  logic [2:0]  wr_class = 0;
  logic [1:0]  wr_frame = 0;
  logic [63:0] wr_data = 0;
  logic        wr_err;
  logic        req_valid = 0, req_ready;
  logic [2:0]  req_class = 0;
  logic        req_err, out_valid;
  logic        out_ready = 1;
  logic [63:0] out_data;
  logic [2:0]  out_class;
  logic [1:0]  out_frame;
  logic        out_last;

  class_hvec_mem dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_class(wr_class), .wr_frame(wr_frame),
    .wr_data(wr_data), .wr_err(wr_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class), .req_err(req_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_class(out_class), .out_frame(out_frame), .out_last(out_last)
  );

  // 6-class instance
  logic        wr_en6 = 0, wr_mode6 = 0;
  logic [2:0]  wr_class6 = 0;
  logic [1:0]  wr_frame6 = 0;
  logic [63:0] wr_data6 = 0;
  logic        wr_err6;
  logic        req_valid6 = 0, req_ready6;
  logic [2:0]  req_class6 = 0;
  logic        req_err6, out_valid6;
  logic        out_ready6 = 1;
  logic [63:0] out_data6;
  logic [2:0]  out_class6;
  logic [1:0]  out_frame6;
  logic        out_last6;

  class_hvec_mem #(.NUM_CLASSES(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en6), .wr_mode(wr_mode6), .wr_class(wr_class6), .wr_frame(wr_frame6),
    .wr_data(wr_data6), .wr_err(wr_err6),
    .req_valid(req_valid6), .req_ready(req_ready6), .req_class(req_class6), .req_err(req_err6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
    .out_class(out_class6), .out_frame(out_frame6), .out_last(out_last6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] c, input logic [1:0] f,
                            input logic [63:0] d, input logic mode);
    wr_en = 1; wr_mode = mode; wr_class = c; wr_frame = f; wr_data = d;
    tick();
    wr_en = 0; wr_mode = 0;
  endtask

  // Requests class c with out_ready=1 and checks the three beats plus the trailing idle.
  task automatic stream_check(input logic [2:0] c, input logic [63:0] e0,
                              input logic [63:0] e1, input logic [63:0] e2, input string nm);
    logic [63:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    out_ready = 1;
    req_valid = 1; req_class = c;
    tick();
    req_valid = 0;
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (out_valid !== 1'b1 || out_frame !== 2'(f) || out_class !== c ||
          out_data !== e[f] || out_last !== (f == 2) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s beat%0d: valid=%b frame=%0d class=%0d data=%h last=%b ready=%b, want valid=1 frame=%0d class=%0d data=%h last=%b ready=0",
                 nm, f, out_valid, out_frame, out_class, out_data, out_last, req_ready,
                 f, c, e[f], (f == 2));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s end: valid=%b ready=%b, want valid=0 ready=1", nm, out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_class !== 0 || out_frame !== 0 ||
        out_last !== 0 || wr_err !== 0 || req_err !== 0 || req_ready !== 0) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h class=%0d frame=%0d last=%b wr_err=%b req_err=%b ready=%b, want all 0",
               out_valid, out_data, out_class, out_frame, out_last, wr_err, req_err, req_ready);
    end
    tick(); tick();
    rst_n = 1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, want ready=1 valid=0", req_ready, out_valid);
    end
  endtask

  task automatic test_stream_zero();
    stream_check(3'd5, 64'h0, 64'h0, 64'h0, "stream_c5_zero");
  endtask

  task automatic test_overwrite();
    write_word(3'd2, 2'd1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    stream_check(3'd2, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, "overwrite_c2");
  endtask

  task automatic test_xor();
    write_word(3'd2, 2'd1, 64'hFFFF_0000_FFFF_0000, 1'b1);
    stream_check(3'd2, 64'h0, 64'h5A5A_A5A5_5A5A_A5A5, 64'h0, "xor_once");
    write_word(3'd2, 2'd1, 64'hFFFF_0000_FFFF_0000, 1'b1);
    stream_check(3'd2, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, "xor_twice");
  endtask

  task automatic test_backpressure();
    req_valid = 1; req_class = 3'd2; out_ready = 1;
    tick();
    req_valid = 0;
    tick();  // beat 0 transfers, beat 1 presented
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin wr_en = 1; wr_class = 3'd2; wr_frame = 2'd1; wr_data = 64'h1; end
      if (i == 1) begin wr_en = 1; wr_class = 3'd2; wr_frame = 2'd2; wr_data = 64'h2; end
      tick();
      wr_en = 0;
      checks++;
      if (out_valid !== 1 || out_frame !== 2'd1 || out_class !== 3'd2 || out_last !== 0 ||
          out_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b frame=%0d class=%0d last=%b data=%h, want 1/1/2/0/a5a5a5a5a5a5a5a5",
                 i, out_valid, out_frame, out_class, out_last, out_data);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1 || out_frame !== 2'd2 || out_last !== 1 || out_data !== 64'h2) begin
      errors++;
      $display("FAIL bp_beat2: valid=%b frame=%0d last=%b data=%h, want 1/2/1/2",
               out_valid, out_frame, out_last, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL bp_end: valid=%b, want 0", out_valid);
    end
    stream_check(3'd2, 64'h0, 64'h1, 64'h2, "bp_stored");
  endtask

  task automatic test_collision();
    req_valid = 1; req_class = 3'd3; out_ready = 1;
    tick();
    req_valid = 0;
    // frame 1 is loaded at the same edge it is written
    wr_en = 1; wr_mode = 0; wr_class = 3'd3; wr_frame = 2'd1; wr_data = 64'h33;
    tick();
    wr_en = 0;
    checks++;
    if (out_frame !== 2'd1 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL collision_prewrite: frame=%0d data=%h, want 1/0", out_frame, out_data);
    end
    tick(); tick();
    stream_check(3'd3, 64'h0, 64'h33, 64'h0, "collision_stored");
  endtask

  task automatic test_back_to_back();
    // request held high across the end of a stream: one idle cycle, then next stream
    req_valid = 1; req_class = 3'd3; out_ready = 1;
    tick(); tick(); tick(); tick();
    checks++;
    if (out_valid !== 0 || req_ready !== 1) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b ready=%b, want 0/1", out_valid, req_ready);
    end
    tick();
    req_valid = 0;
    checks++;
    if (out_valid !== 1 || out_frame !== 2'd0 || out_class !== 3'd3) begin
      errors++;
      $display("FAIL b2b_restart: valid=%b frame=%0d class=%0d, want 1/0/3", out_valid, out_frame, out_class);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_range();
    req_valid6 = 1; req_class6 = 3'd7;
    tick();
    req_valid6 = 0;
    checks++;
    if (req_err6 !== 1 || out_valid6 !== 0) begin
      errors++;
      $display("FAIL req_oor: req_err=%b valid=%b, want 1/0", req_err6, out_valid6);
    end
    tick();
    checks++;
    if (req_err6 !== 0 || out_valid6 !== 0 || req_ready6 !== 1) begin
      errors++;
      $display("FAIL req_oor_after: req_err=%b valid=%b ready=%b, want 0/0/1", req_err6, out_valid6, req_ready6);
    end
    wr_en6 = 1; wr_class6 = 3'd6; wr_frame6 = 2'd0; wr_data6 = '1;
    tick();
    checks++;
    if (wr_err6 !== 1) begin
      errors++;
      $display("FAIL wr_oor_class: wr_err=%b, want 1", wr_err6);
    end
    wr_class6 = 3'd0; wr_frame6 = 2'd3;
    tick();
    wr_en6 = 0;
    checks++;
    if (wr_err6 !== 1) begin
      errors++;
      $display("FAIL wr_oor_frame: wr_err=%b, want 1", wr_err6);
    end
    tick();
    checks++;
    if (wr_err6 !== 0) begin
      errors++;
      $display("FAIL wr_err_pulse: wr_err=%b, want 0", wr_err6);
    end
    for (int c = 0; c < 6; c++) begin
      req_valid6 = 1; req_class6 = 3'(c);
      tick();
      req_valid6 = 0;
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (out_valid6 !== 1 || out_data6 !== 64'h0 || out_frame6 !== 2'(f) || out_class6 !== 3'(c)) begin
          errors++;
          $display("FAIL oor_unchanged c%0d f%0d: valid=%b data=%h frame=%0d class=%0d, want 1/0/%0d/%0d",
                   c, f, out_valid6, out_data6, out_frame6, out_class6, f, c);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_class = 3'd2; out_ready = 1;
    tick();
    req_valid = 0;
    tick();  // beat 1 presented
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_frame !== 0 || out_class !== 0 || out_last !== 0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h frame=%0d class=%0d last=%b, want all 0",
               out_valid, out_data, out_frame, out_class, out_last);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (req_ready !== 1 || out_valid !== 0) begin
      errors++;
      $display("FAIL reset_mid_release: ready=%b valid=%b, want 1/0", req_ready, out_valid);
    end
    stream_check(3'd0, 64'h0, 64'h0, 64'h0, "post_reset_c0");
    stream_check(3'd2, 64'h0, 64'h0, 64'h0, "post_reset_c2");
  endtask

  initial begin
    test_reset();
    test_stream_zero();
    test_overwrite();
    test_xor();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
